conv_kernel_mc: RTL and testbench

CONV_KERNEL_MC -- requirements
Module: conv_kernel_mc

---
 rtl/conv_pkg.sv | 100 ++++++++++
 rtl/conv_lane.sv | 85 ++++++++
 rtl/conv_kernel_mc.sv | 71 +++++++
 tb/tb_conv_kernel_mc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ============================================================================
// conv_pkg -- fp16 types, kernel constants and fp16 mul/add helpers.
// Rev 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

  typedef logic [15:0] fp16_t;

  localparam int KTAPS    = 9;
  localparam int CONV_LAT = 6;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  // Round-to-nearest-even; subnormal results flush to signed zero, overflow saturates to inf.
  function automatic fp16_t fp16_pack(input logic s, input logic signed [7:0] e,
                                      input logic [9:0] f, input logic g, input logic st);
    logic [10:0]       r;
    logic signed [7:0] ex;
    r  = {1'b0, f} + {10'b0, g & (st | f[0])};
    ex = r[10] ? e + 8'sd1 : e;
    if (ex >= 8'sd31) return {s, 15'h7C00};
    if (ex <= 8'sd0)  return {s, 15'h0000};
    return {s, ex[4:0], r[9:0]};
  endfunction

  function automatic fp16_t fp16_mul(input fp16_t a, input fp16_t b);
    logic              s;
    logic [21:0]       p;
    logic signed [7:0] e;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    s      = a[15] ^ b[15];
    a_zero = (a[14:10] == 5'h00);
    b_zero = (b[14:10] == 5'h00);
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 16'h7E00;
    if (a_inf || b_inf)   return {s, 15'h7C00};
    if (a_zero || b_zero) return {s, 15'h0000};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = $signed({3'b0, a[14:10]}) + $signed({3'b0, b[14:10]}) - 8'sd15;
    if (p[21]) return fp16_pack(s, e + 8'sd1, p[20:11], p[10], |p[9:0]);
    return fp16_pack(s, e, p[19:10], p[9], |p[8:0]);
  endfunction

  function automatic fp16_t fp16_add(input fp16_t a, input fp16_t b);
    fp16_t             x, y;
    logic [4:0]        d;
    logic [26:0]       yt;
    logic [13:0]       xm, ym, n;
    logic [14:0]       sm;
    logic signed [7:0] e;
    int                lz;
    logic a_inf, b_inf, a_nan, b_nan;
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) return 16'h7E00;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a[14:0] >= b[14:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    // Three extra bits (guard, round, sticky) carried through alignment.
    xm = (x[14:10] == 5'h00) ? 14'h0 : {1'b1, x[9:0], 3'b000};
    yt = (y[14:10] == 5'h00) ? 27'h0 : {1'b1, y[9:0], 16'h0000};
    d  = x[14:10] - y[14:10];
    yt = yt >> d;
    ym = {yt[26:14], |yt[13:0]};
    e  = $signed({3'b0, x[14:10]});
    if (x[15] == y[15]) begin
      sm = {1'b0, xm} + {1'b0, ym};
      if (sm[14]) begin
        n = {sm[14:2], sm[1] | sm[0]};
        e = e + 8'sd1;
      end else begin
        n = sm[13:0];
      end
    end else begin
      sm = {1'b0, xm} - {1'b0, ym};
      n  = sm[13:0];
      lz = 0;
      for (int i = 0; i < 14; i++) if (n[i]) lz = 13 - i;
      n = n << lz;
      e = e - 8'(lz);
    end
    if (n == 14'h0) return {x[15] & y[15], 15'h0000};
    return fp16_pack(x[15], e, n[12:3], n[2], |n[1:0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_lane.sv
// ============================================================================
// conv_lane -- one output channel: 9 fp16 products, 9->5->3->2->1 tree, accumulator.
// CONV_RELU_EN clamps negative results on ofmap only. Rev 1.0
// ============================================================================
`default_nettype none

module conv_lane
  import conv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  fp16_t [KTAPS-1:0]       win_i,
  input  fp16_t [KTAPS-1:0]       wgt_i,
  input  logic                    vld_i,
  input  logic                    first_i,
  input  logic                    last_i,
  output fp16_t                   ofmap_o
);

  fp16_t [KTAPS-1:0] w_q, prod_q, prod_d;
  fp16_t [4:0]       l2_q, l2_d;
  fp16_t [2:0]       l3_q, l3_d;
  fp16_t [1:0]       l4_q, l4_d;
  fp16_t             l5_q, l5_d;
  fp16_t             acc_q, acc_d;
  fp16_t             ofmap_q, ofmap_d;
  fp16_t             sum;

  always_comb begin
    for (int k = 0; k < KTAPS; k++) prod_d[k] = fp16_mul(win_i[k], w_q[k]);
    l2_d[0] = fp16_add(prod_q[0], prod_q[1]);
    l2_d[1] = fp16_add(prod_q[2], prod_q[3]);
    l2_d[2] = fp16_add(prod_q[4], prod_q[5]);
    l2_d[3] = fp16_add(prod_q[6], prod_q[7]);
    l2_d[4] = prod_q[8];
    l3_d[0] = fp16_add(l2_q[0], l2_q[1]);
    l3_d[1] = fp16_add(l2_q[2], l2_q[3]);
    l3_d[2] = l2_q[4];
    l4_d[0] = fp16_add(l3_q[0], l3_q[1]);
    l4_d[1] = l3_q[2];
    l5_d    = fp16_add(l4_q[0], l4_q[1]);

    sum     = first_i ? l5_q : fp16_add(acc_q, l5_q);
    acc_d   = acc_q;
    ofmap_d = ofmap_q;
    if (vld_i) begin
      acc_d = sum;
      if (last_i) begin
`ifdef CONV_RELU_EN
        ofmap_d = sum[15] ? 16'h0000 : sum;
`else
        ofmap_d = sum;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q     <= '0;
      prod_q  <= '0;
      l2_q    <= '0;
      l3_q    <= '0;
      l4_q    <= '0;
      l5_q    <= '0;
      acc_q   <= '0;
      ofmap_q <= '0;
    end else if (en_i) begin
      w_q     <= wgt_i;
      prod_q  <= prod_d;
      l2_q    <= l2_d;
      l3_q    <= l3_d;
      l4_q    <= l4_d;
      l5_q    <= l5_d;
      acc_q   <= acc_d;
      ofmap_q <= ofmap_d;
    end
  end

  assign ofmap_o = ofmap_q;

endmodule

`default_nettype wire

// File: rtl/conv_kernel_mc.sv
// ============================================================================
// conv_kernel_mc -- multi-channel 3x3 fp16 conv kernel: shared window, OUT_CH lanes,
// tag pipeline and valid/ready handshake. Optional macro: CONV_RELU_EN. Rev 1.0
// ============================================================================
`default_nettype none

module conv_kernel_mc
  import conv_pkg::*;
#(
  parameter int OUT_CH = 2,
  parameter int DW     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [8:0][DW-1:0]            ifmap_3x3,
  input  logic [OUT_CH-1:0][8:0][DW-1:0] weight_3x3,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_CH-1:0][DW-1:0]     ofmap
);

  logic                  en;
  fp16_t [KTAPS-1:0]     win_q;
  tag_t  [CONV_LAT-1:0]  tag_q, tag_d;
  logic                  out_valid_q, out_valid_d;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;

  // Tag slot 0 aligns with the captured beat; slot CONV_LAT-1 with the tree result.
  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = '{valid: in_valid, first: in_first, last: in_last};
    for (int i = 1; i < CONV_LAT; i++) tag_d[i] = tag_q[i-1];
    out_valid_d = tag_q[CONV_LAT-1].valid && tag_q[CONV_LAT-1].last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q       <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      win_q       <= ifmap_3x3;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar c = 0; c < OUT_CH; c++) begin : g_lane
    conv_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en),
      .win_i   (win_q),
      .wgt_i   (weight_3x3[c]),
      .vld_i   (tag_q[CONV_LAT-1].valid),
      .first_i (tag_q[CONV_LAT-1].first),
      .last_i  (tag_q[CONV_LAT-1].last),
      .ofmap_o (ofmap[c])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_kernel_mc.sv
// ============================================================================
// tb_conv_kernel_mc -- directed self-checking bench for conv_kernel_mc. Rev 1.0
// ============================================================================
`default_nettype none

module tb_conv_kernel_mc;

  localparam int OUT_CH = 2;

`ifdef CONV_RELU_EN
  localparam logic [15:0] NEG9  = 16'h0000;
  localparam logic [15:0] NEG18 = 16'h0000;
`else
  localparam logic [15:0] NEG9  = 16'hC880;
  localparam logic [15:0] NEG18 = 16'hCC80;
`endif

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       in_valid, in_ready, in_first, in_last;
  logic [8:0][15:0]           ifmap_3x3;
  logic [OUT_CH-1:0][8:0][15:0] weight_3x3;
  logic                       out_valid, out_ready;
  logic [OUT_CH-1:0][15:0]    ofmap;

  int          n_run  = 0;
  int          n_fail = 0;
  logic [31:0] res_q[$];

  conv_kernel_mc #(.OUT_CH(OUT_CH), .DW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_first   (in_first),
    .in_last    (in_last),
    .ifmap_3x3  (ifmap_3x3),
    .weight_3x3 (weight_3x3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ofmap      (ofmap)
  );

  always #5 clk = ~clk;

  // Every consumed result, recorded between edges.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) res_q.push_back(ofmap);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res_at(input int i);
    return (i < res_q.size()) ? res_q[i] : 32'hxxxxxxxx;
  endfunction

  task automatic drive_pt();
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_pt();
  endtask

  task automatic beat(input logic f, input logic l, input logic [15:0] x,
                      input logic [15:0] w0, input logic [15:0] w1);
    int guard = 0;
    in_valid   = 1'b1;
    in_first   = f;
    in_last    = l;
    ifmap_3x3  = {9{x}};
    weight_3x3 = {{9{w1}}, {9{w0}}};
    while (!in_ready && guard < 50) begin
      drive_pt();
      guard++;
    end
    if (!in_ready) check("beat_accept", {31'b0, in_ready}, 32'd1);
    drive_pt();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      drive_pt();
      lat++;
    end
  endtask

  logic [15:0] stall_x  [4] = '{16'h3C00, 16'h4000, 16'h3800, 16'hBC00};
  logic [31:0] stall_exp[4] = '{{16'h4C80, 16'h4880}, {16'h5080, 16'h4C80},
                                {16'h4880, 16'h4480}, {NEG18, NEG9}};

  initial begin
    int lat;
    in_valid   = 1'b0;
    in_first   = 1'b0;
    in_last    = 1'b0;
    ifmap_3x3  = '0;
    weight_3x3 = '0;
    out_ready  = 1'b1;
    rst        = 1'b1;
    idle(3);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_ofmap",     ofmap, 32'h0);
    check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    idle(2);

    // Single beat, all ones: 9.0 per channel, six edges after accept.
    res_q.delete();
    beat(1'b1, 1'b1, 16'h3C00, 16'h3C00, 16'h3C00);
    wait_out(lat);
    check("single_latency", lat, 32'd6);
    check("single_ofmap", ofmap, {16'h4880, 16'h4880});
    drive_pt();
    check("single_clear", {31'b0, out_valid}, 32'd0);
    check("single_count", res_q.size(), 32'd1);

    // Two-beat accumulation: one result of 18.0.
    res_q.delete();
    beat(1'b1, 1'b0, 16'h3C00, 16'h3C00, 16'h3C00);
    beat(1'b0, 1'b1, 16'h3C00, 16'h3C00, 16'h3C00);
    idle(12);
    check("acc2_count", res_q.size(), 32'd1);
    check("acc2_ofmap", res_at(0), {16'h4C80, 16'h4C80});

    // Opposite-sign channel weights.
    res_q.delete();
    beat(1'b1, 1'b1, 16'h3C00, 16'h3C00, 16'hBC00);
    idle(10);
    check("sign_count", res_q.size(), 32'd1);
    check("sign_ofmap", res_at(0), {NEG9, 16'h4880});

    // Back-pressure: stall after the first result, then drain in order.
    res_q.delete();
    for (int k = 0; k < 4; k++) beat(1'b1, 1'b1, stall_x[k], 16'h3C00, 16'h4000);
    wait_out(lat);
    out_ready = 1'b0;
    idle(5);
    check("stall_in_ready",  {31'b0, in_ready}, 32'd0);
    check("stall_out_valid", {31'b0, out_valid}, 32'd1);
    check("stall_frozen",    ofmap, stall_exp[0]);
    out_ready = 1'b1;
    idle(10);
    check("drain_count", res_q.size(), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("drain_%0d", k), res_at(k), stall_exp[k]);

    // Reset between first and last beat abandons the accumulation.
    res_q.delete();
    beat(1'b1, 1'b0, 16'h3C00, 16'h3C00, 16'h3C00);
    idle(1);
    rst = 1'b1;
    idle(2);
    check("midrst_in_reset_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    idle(12);
    check("midrst_count", res_q.size(), 32'd0);
    beat(1'b1, 1'b1, 16'h3C00, 16'h3C00, 16'h3C00);
    wait_out(lat);
    check("midrst_fresh_latency", lat, 32'd6);
    check("midrst_fresh_ofmap", ofmap, {16'h4880, 16'h4880});
    idle(3);

    // A new first beat discards the running sum of 18.0.
    res_q.delete();
    beat(1'b1, 1'b0, 16'h4000, 16'h3C00, 16'h3C00);
    beat(1'b1, 1'b1, 16'h3C00, 16'h3C00, 16'h3C00);
    idle(12);
    check("refirst_count", res_q.size(), 32'd1);
    check("refirst_ofmap", res_at(0), {16'h4880, 16'h4880});

    // Last beat without a first accumulates onto acc (9.0 + 9.0).
    res_q.delete();
    beat(1'b0, 1'b1, 16'h3C00, 16'h3C00, 16'h3C00);
    idle(12);
    check("nofirst_count", res_q.size(), 32'd1);
    check("nofirst_ofmap", res_at(0), {16'h4C80, 16'h4C80});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
